// File: rtl/cpu_exec_ctrl_if.sv
// Execution controller bus: board-side inputs and CPU-side outputs.
// master = board/CPU side, slave = cpu_exec_ctrl.
interface cpu_exec_ctrl_if #(
    parameter int PC_W = 32
);
    logic            run_sw;
    logic            step_btn;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc;
    logic            cpu_ena;
    logic [1:0]      state_o;
    logic            bp_hit;
    logic [31:0]     retired;

    modport master (
        output run_sw, step_btn, bp_en, bp_addr, pc,
        input  cpu_ena, state_o, bp_hit, retired
    );

    modport slave (
        input  run_sw, step_btn, bp_en, bp_addr, pc,
        output cpu_ena, state_o, bp_hit, retired
    );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// CPU execution controller: run / single-step / breakpoint enable pulses
// on the board clock, plus a retired-instruction counter.
module cpu_exec_ctrl #(
    parameter int RUN_DIV   = 1_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input logic            clk,
    input logic            rst,
    cpu_exec_ctrl_if.slave bus
);
    localparam logic [1:0] S_HALT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_BRK  = 2'd3;

    localparam int TW = $clog2(RUN_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(RUN_DIV - 1);
    localparam logic [DW-1:0] DB_MAX   = DW'(DB_CYCLES - 1);

    logic          run_s1_q, run_s2_q;
    logic          stp_s1_q, stp_s2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          db_lvl_q, db_lvl_d;
    logic          db_prev_q;
    logic          step_req;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [1:0]    state_q, state_d;
    logic          skip_q, skip_d;
    logic          ena_q, ena_d;
    logic [31:0]   ret_q;
    logic          bp_match;

    // Two-flop synchronisers for the raw switch and button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            stp_s1_q <= 1'b0;
            stp_s2_q <= 1'b0;
        end else begin
            run_s1_q <= bus.run_sw;
            run_s2_q <= run_s1_q;
            stp_s1_q <= bus.step_btn;
            stp_s2_q <= stp_s1_q;
        end
    end

    // Debounce: flip the level after DB_CYCLES differing samples in a row.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (stp_s2_q != db_lvl_q) begin
            if (db_cnt_q == DB_MAX) db_lvl_d = stp_s2_q;
            else                    db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign step_req = db_lvl_q & ~db_prev_q;
    assign tick     = (state_q == S_RUN) && (cnt_q == TICK_MAX);
    assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);

    // Next-state, pulse decision and resume-skip flag.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        ena_d   = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (run_s2_q) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end else if (step_req) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run_s2_q) begin
                    state_d = S_HALT;
                end else if (tick) begin
                    if (bp_match && !skip_q) begin
                        state_d = S_BRK;
                    end else begin
                        ena_d  = 1'b1;
                        skip_d = 1'b0;
                    end
                end
            end
            S_STEP: begin
                ena_d   = 1'b1;
                state_d = S_HALT;
            end
            S_BRK: begin
                if (!run_s2_q) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Divider runs only while staying in RUN; restarts from 0 on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_RUN && state_d == S_RUN && !tick)
            cnt_d = cnt_q + 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q  <= '0;
            db_lvl_q  <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_HALT;
            skip_q    <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            skip_q    <= skip_d;
            ena_q     <= ena_d;
        end
    end

    // Retired counter advances once per enable pulse, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       ret_q <= '0;
        else if (ena_q) ret_q <= ret_q + 32'd1;
    end

    assign bus.cpu_ena = ena_q;
    assign bus.state_o = state_q;
    assign bus.bp_hit  = (state_q == S_BRK);
    assign bus.retired = ret_q;
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl with RUN_DIV=4, DB_CYCLES=3.
// pc advances by 4 on every observed cpu_ena pulse.
module tb_cpu_exec_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   npulse;
    int   width_err;
    int   gap_err;
    int   cyc_n;
    int   last_p;
    bit   chk_gap;
    bit   prev_ena;
    bit   saw_step;
    int   p0;
    bit   found;

    cpu_exec_ctrl_if #(.PC_W(32)) bus ();

    cpu_exec_ctrl #(
        .RUN_DIV  (4),
        .DB_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; sample at the falling edge and emulate the CPU's pc.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (bus.state_o == 2'd2) saw_step = 1'b1;
        if (bus.cpu_ena) begin
            npulse++;
            bus.pc = bus.pc + 32'd4;
            if (prev_ena) width_err++;
            if (chk_gap && last_p >= 0 && (cyc_n - last_p) != 4) gap_err++;
            last_p = cyc_n;
        end
        prev_ena = bus.cpu_ena;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; npulse = 0; width_err = 0; gap_err = 0;
        cyc_n = 0; last_p = -1; chk_gap = 1'b0; prev_ena = 1'b0;
        saw_step = 1'b0;
        rst = 1'b0;
        bus.run_sw = 1'b0;
        bus.step_btn = 1'b0;
        bus.bp_en = 1'b0;
        bus.bp_addr = 32'h0;
        bus.pc = 32'h0;

        cycn(3);
        chk("rst_state", {30'd0, bus.state_o}, 32'd0);
        chk("rst_ena", {31'd0, bus.cpu_ena}, 32'd0);
        chk("rst_bphit", {31'd0, bus.bp_hit}, 32'd0);
        chk("rst_retired", bus.retired, 32'd0);

        // 1: free run for 40 clocks
        rst = 1'b1;
        bus.run_sw = 1'b1;
        chk_gap = 1'b1;
        cycn(40);
        chk_gap = 1'b0;
        chk("run_pulses", npulse, 32'd9);
        chk("run_retired", bus.retired, 32'd9);
        chk("run_state", {30'd0, bus.state_o}, 32'd1);
        chk("run_gap", gap_err, 32'd0);

        // halt: switch-off beats the coinciding tick
        bus.run_sw = 1'b0;
        cycn(5);
        chk("halt_state", {30'd0, bus.state_o}, 32'd0);
        chk("halt_retired", bus.retired, 32'd9);

        // 2: single step
        p0 = npulse;
        saw_step = 1'b0;
        bus.step_btn = 1'b1;
        cycn(10);
        bus.step_btn = 1'b0;
        cycn(10);
        chk("step_pulses", npulse - p0, 32'd1);
        chk("step_retired", bus.retired, 32'd10);
        chk("step_seen", {31'd0, saw_step}, 32'd1);
        chk("step_state", {30'd0, bus.state_o}, 32'd0);

        // 3: short glitch is filtered
        p0 = npulse;
        saw_step = 1'b0;
        bus.step_btn = 1'b1;
        cycn(2);
        bus.step_btn = 1'b0;
        cycn(10);
        chk("glitch_pulses", npulse - p0, 32'd0);
        chk("glitch_retired", bus.retired, 32'd10);
        chk("glitch_nostep", {31'd0, saw_step}, 32'd0);

        // 4: breakpoint at 0x10 from pc 0
        bus.pc = 32'h0;
        bus.bp_en = 1'b1;
        bus.bp_addr = 32'h10;
        p0 = npulse;
        bus.run_sw = 1'b1;
        cycn(40);
        chk("bp_pulses", npulse - p0, 32'd4);
        chk("bp_state", {30'd0, bus.state_o}, 32'd3);
        chk("bp_hit", {31'd0, bus.bp_hit}, 32'd1);
        chk("bp_pc", bus.pc, 32'h10);

        // step is ignored in BREAK
        bus.step_btn = 1'b1;
        cycn(10);
        bus.step_btn = 1'b0;
        cycn(8);
        chk("bp_step_ign", npulse - p0, 32'd4);

        // 5: resume past the breakpoint
        bus.run_sw = 1'b0;
        cycn(5);
        chk("res_halt", {30'd0, bus.state_o}, 32'd0);
        chk("res_bphit0", {31'd0, bus.bp_hit}, 32'd0);
        p0 = npulse;
        bus.run_sw = 1'b1;
        cycn(8);
        chk("res_first", npulse - p0, 32'd1);
        chk("res_pc1", bus.pc, 32'h14);
        chk("res_state", {30'd0, bus.state_o}, 32'd1);
        cycn(8);
        chk("res_pc2", bus.pc, 32'h1C);
        chk("res_retired", bus.retired, 32'd17);

        // 6a: reset while cpu_ena is high
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (bus.cpu_ena) found = 1'b1;
        end
        chk("mid_found", {31'd0, found}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_ena", {31'd0, bus.cpu_ena}, 32'd0);
        chk("mid_retired", bus.retired, 32'd0);
        chk("mid_state", {30'd0, bus.state_o}, 32'd0);
        bus.run_sw = 1'b0;
        bus.bp_en = 1'b0;
        cycn(2);
        prev_ena = 1'b0;
        rst = 1'b1;
        cycn(3);

        // 6b: wrap of retired
        force dut.ret_q = 32'hFFFF_FFFF;
        cyc();
        release dut.ret_q;
        cyc();
        chk("wrap_pre", bus.retired, 32'hFFFF_FFFF);
        p0 = npulse;
        bus.step_btn = 1'b1;
        cycn(10);
        bus.step_btn = 1'b0;
        cycn(6);
        chk("wrap_pulse", npulse - p0, 32'd1);
        chk("wrap_retired", bus.retired, 32'd0);

        chk("pulse_width", width_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
